// File: rtl/knight_tour_checker.sv
`default_nettype none
// ============================================================================
// Module   : knight_tour_checker
// Purpose  : Consumes a knight's-tour move stream one square per handshake and
//            checks bounds, knight-step legality and revisits. Reports
//            pass/fail, the failing step index and the error class.
// Revision : 1.0 - initial release
// ============================================================================
module knight_tour_checker #(
  parameter int DIM = 5,
  parameter int CW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  input  logic          in_last,
  output logic          done,
  output logic          pass,
  output logic [2:0]    err_code,
  output logic [6:0]    err_step,
  output logic [6:0]    step_cnt
);

  localparam int CELLS = DIM * DIM;
  // Bitmap index is at least 7 bits wide so DIM*x+y never wraps for DIM<=11.
  localparam int IW    = ($clog2(CELLS) > 7) ? $clog2(CELLS) : 7;

  localparam logic [2:0]  C_ERR_NONE    = 3'd0;
  localparam logic [2:0]  C_ERR_BOUNDS  = 3'd1;
  localparam logic [2:0]  C_ERR_MOVE    = 3'd2;
  localparam logic [2:0]  C_ERR_REVISIT = 3'd3;
  localparam logic [2:0]  C_ERR_SHORT   = 3'd4;
  localparam logic [CW:0] C_DIM_W       = (CW+1)'(DIM);
  localparam logic [CW:0] C_ONE         = (CW+1)'(1);
  localparam logic [CW:0] C_TWO         = (CW+1)'(2);
  localparam logic [6:0]  C_CELLS_W     = 7'(CELLS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] bitmap_q, bitmap_d;
  logic [CW-1:0]    prev_x_q, prev_x_d;
  logic [CW-1:0]    prev_y_q, prev_y_d;
  logic             in_ready_q, in_ready_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [6:0]       err_step_q, err_step_d;
  logic [6:0]       step_cnt_q, step_cnt_d;

  logic             w_in_bounds;
  logic signed [CW:0] w_dx, w_dy;
  logic [CW:0]      w_adx, w_ady;
  logic             w_knight_ok;
  logic [IW-1:0]    w_idx;
  logic [CELLS-1:0] w_onehot;
  logic             w_revisit;
  logic [6:0]       w_step_next;

  // Per-move checks: bounds, knight geometry and visited-bitmap lookup.
  always_comb begin
    w_in_bounds = ({1'b0, in_x} < C_DIM_W) && ({1'b0, in_y} < C_DIM_W);
    w_dx        = $signed({1'b0, in_x}) - $signed({1'b0, prev_x_q});
    w_dy        = $signed({1'b0, in_y}) - $signed({1'b0, prev_y_q});
    w_adx       = w_dx[CW] ? (CW+1)'(-w_dx) : (CW+1)'(w_dx);
    w_ady       = w_dy[CW] ? (CW+1)'(-w_dy) : (CW+1)'(w_dy);
    w_knight_ok = ((w_adx == C_ONE) && (w_ady == C_TWO)) ||
                  ((w_adx == C_TWO) && (w_ady == C_ONE));
    // Index is forced to 0 when out of bounds; the one-hot shift yields an
    // all-zero mask for any index past the board, so no stray bit is touched.
    w_idx       = w_in_bounds ? (IW'(DIM) * IW'(in_x) + IW'(in_y)) : '0;
    w_onehot    = w_in_bounds ? (CELLS'(1) << w_idx) : '0;
    w_revisit   = |(bitmap_q & w_onehot);
    w_step_next = step_cnt_q + 7'd1;
  end

  // Next-state and registered-output computation for the checker FSM.
  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_code_d = err_code_q;
    err_step_d = err_step_q;
    step_cnt_d = step_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A move presented alongside start is not consumed.
        if (start) begin
          state_d    = S_FIRST;
          bitmap_d   = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_code_d = C_ERR_NONE;
          err_step_d = 7'd0;
          step_cnt_d = 7'd0;
        end
      end
      S_FIRST, S_RUN: begin
        if (in_valid) begin
          if (!w_in_bounds ||
              ((state_q == S_RUN) && (!w_knight_ok || w_revisit))) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            pass_d     = 1'b0;
            err_step_d = w_step_next;
            if (!w_in_bounds)      err_code_d = C_ERR_BOUNDS;
            else if (!w_knight_ok) err_code_d = C_ERR_MOVE;
            else                   err_code_d = C_ERR_REVISIT;
          end else begin
            state_d    = S_RUN;
            bitmap_d   = bitmap_q | w_onehot;
            prev_x_d   = in_x;
            prev_y_d   = in_y;
            step_cnt_d = w_step_next;
            // Completing the board wins over in_last.
            if (w_step_next == C_CELLS_W) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              pass_d     = 1'b1;
              err_code_d = C_ERR_NONE;
            end else if (in_last) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              pass_d     = 1'b0;
              err_code_d = C_ERR_SHORT;
              err_step_d = w_step_next;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_FIRST) || (state_d == S_RUN);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bitmap_q   <= '0;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_code_q <= C_ERR_NONE;
      err_step_q <= 7'd0;
      step_cnt_q <= 7'd0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_code_q <= err_code_d;
      err_step_q <= err_step_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_code = err_code_q;
  assign err_step = err_step_q;
  assign step_cnt = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_knight_tour_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_knight_tour_checker
// Purpose  : Directed self-checking bench for knight_tour_checker (DIM=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_knight_tour_checker;

  localparam int DIM = 5;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [CW-1:0] in_x = '0;
  logic [CW-1:0] in_y = '0;
  logic          in_ready;
  logic          done;
  logic          pass;
  logic [2:0]    err_code;
  logic [6:0]    err_step;
  logic [6:0]    step_cnt;

  knight_tour_checker #(.DIM(DIM), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_last  (in_last),
    .done     (done),
    .pass     (pass),
    .err_code (err_code),
    .err_step (err_step),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pass;
    logic [2:0] code;
    logic [6:0] step;
    logic [6:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Fixed open tour of the 5x5 board starting in the corner.
  int tx[25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,0,1,3,4,3,1,0,2,4,3,1,2};
  int ty[25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,1,3,4,2,0,1,3,4,3,1,0,2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic move(input int x, input int y, input logic last);
    in_valid = 1'b1;
    in_x     = CW'(x);
    in_y     = CW'(y);
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_res(input logic p, input int code, input int step, input int cnt);
    exp_t e;
    e.pass = p;
    e.code = 3'(code);
    e.step = 7'(step);
    e.cnt  = 7'(cnt);
    sb.push_back(e);
  endtask

  // Called the cycle after the deciding transfer: the result must already show.
  task automatic check_res(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".done"},     32'(done),     32'd1);
      chk({tag, ".pass"},     32'(pass),     32'(e.pass));
      chk({tag, ".err_code"}, 32'(err_code), 32'(e.code));
      chk({tag, ".err_step"}, 32'(err_step), 32'(e.step));
      chk({tag, ".step_cnt"}, 32'(step_cnt), 32'(e.cnt));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    end
  endtask

  task automatic full_tour(input string tag);
    expect_res(1'b1, 0, 0, 25);
    for (int i = 0; i < 25; i++) begin
      move(tx[i], ty[i], i == 24);
      if (i == 12) begin
        chk({tag, ".mid_cnt"},  32'(step_cnt), 32'd13);
        chk({tag, ".mid_done"}, 32'(done),     32'd0);
      end
    end
    check_res(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.done",     32'(done),     32'd0);
    chk("rst.step_cnt", 32'(step_cnt), 32'd0);

    // IDLE ignores moves
    move(0, 0, 1'b0);
    chk("idle.step_cnt", 32'(step_cnt), 32'd0);
    chk("idle.in_ready", 32'(in_ready), 32'd0);

    // T2 full tour
    do_start();
    chk("arm.in_ready", 32'(in_ready), 32'd1);
    full_tour("T2");

    // DONE holds outputs and refuses moves
    move(1, 2, 1'b0);
    chk("hold.done",     32'(done),     32'd1);
    chk("hold.step_cnt", 32'(step_cnt), 32'd25);

    // start with in_valid in DONE: re-arm, move not taken
    start = 1'b1;
    move(0, 0, 1'b0);
    start = 1'b0;
    chk("rearm.done",     32'(done),     32'd0);
    chk("rearm.step_cnt", 32'(step_cnt), 32'd0);
    chk("rearm.in_ready", 32'(in_ready), 32'd1);

    // T3 bad step
    expect_res(1'b0, 2, 2, 1);
    move(0, 0, 1'b0);
    move(1, 1, 1'b0);
    check_res("T3");

    // T4 revisit
    do_start();
    expect_res(1'b0, 3, 3, 2);
    move(0, 0, 1'b0);
    move(2, 1, 1'b0);
    move(0, 0, 1'b0);
    check_res("T4");

    // T5 bounds beats move
    do_start();
    expect_res(1'b0, 1, 2, 1);
    move(0, 0, 1'b0);
    move(31, 2, 1'b0);
    check_res("T5a");
    do_start();
    expect_res(1'b0, 1, 2, 1);
    move(0, 0, 1'b0);
    move(5, 1, 1'b0);
    check_res("T5b");

    // Out-of-bounds first move
    do_start();
    expect_res(1'b0, 1, 1, 0);
    move(0, 5, 1'b0);
    check_res("first_bounds");

    // T6 short tour
    do_start();
    expect_res(1'b0, 4, 2, 2);
    move(0, 0, 1'b0);
    move(1, 2, 1'b1);
    check_res("T6short");

    // Partial tour, start ignored while running, then async reset mid-cycle
    do_start();
    for (int i = 0; i < 10; i++) move(tx[i], ty[i], 1'b0);
    chk("T6.cnt10", 32'(step_cnt), 32'd10);
    start = 1'b1;
    move(tx[10], ty[10], 1'b0);
    start = 1'b0;
    chk("T6.start_ign_cnt",   32'(step_cnt), 32'd11);
    chk("T6.start_ign_ready", 32'(in_ready), 32'd1);

    // T1 reset without a clock edge
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("T1.done",     32'(done),     32'd0);
    chk("T1.pass",     32'(pass),     32'd0);
    chk("T1.in_ready", 32'(in_ready), 32'd0);
    chk("T1.err_code", 32'(err_code), 32'd0);
    chk("T1.step_cnt", 32'(step_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Replay the tour: any bitmap residue would show as a revisit
    do_start();
    full_tour("T6replay");

    chk("sb.empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
